// File: rtl/pc_sequencer_if.sv
// Fetch-stage bus: start/halt control, instruction-memory port, decode handshake,
// branch-unit redirect inputs and return-address/status outputs.
interface pc_sequencer_if #(
    parameter int PC_W = 8
);
    logic            start;
    logic            halt;
    logic [PC_W-1:0] imem_addr;
    logic            imem_en;
    logic [31:0]     imem_data;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            PC_select;
    logic [PC_W-1:0] branch_PC;
    logic            is_call;
    logic            is_ret;
    logic [31:0]     ra;
    logic            halted;
    logic            ras_err;

    modport master (
        input  start, halt, imem_data, instr_ready, PC_select, branch_PC, is_call, is_ret,
        output imem_addr, imem_en, instr, instr_pc, instr_valid, ra, halted, ras_err
    );

    modport slave (
        output start, halt, imem_data, instr_ready, PC_select, branch_PC, is_call, is_ret,
        input  imem_addr, imem_en, instr, instr_pc, instr_valid, ra, halted, ras_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and fetch stage: drives a synchronous instruction ROM, presents
// each word to decode with valid/ready, applies branch redirects and keeps a return-address stack.
module pc_sequencer #(
    parameter int              PC_W      = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_VALID = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              r_imem_en;
    logic              r_valid;
    logic              r_halted;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic [PC_W-1:0]   r_instr_pc;
    logic [PC_W-1:0]   r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ras_err;
    logic              w_push;
    logic              w_pop;
    logic [PC_W-1:0]   w_push_val;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_empty;
    logic              w_full;

    // Next-state decode; accept only exists while an instruction is presented
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: w_state_nxt = ST_LATCH;
            ST_LATCH: w_state_nxt = ST_VALID;
            ST_VALID: begin
                if (bus.instr_ready) begin
                    w_accept = 1'b1;
                    if (bus.halt) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    w_state_nxt = ST_VALID;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register with registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_imem_en <= 1'b0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_imem_en <= (w_state_nxt == ST_FETCH);
            r_valid   <= (w_state_nxt == ST_VALID);
            r_halted  <= (w_state_nxt == ST_HALT);
        end
    end

    // Program counter: advances or redirects on a non-halting accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_accept && !bus.halt) begin
            r_pc <= bus.PC_select ? bus.branch_PC : r_pc + PC_W'(1);
        end else begin
            r_pc <= r_pc;
        end
    end

    // ROM data arrives the cycle after the read, so capture it in LATCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= 32'h0000_0000;
            r_instr_pc <= {PC_W{1'b0}};
        end else if (r_state == ST_LATCH) begin
            r_instr    <= bus.imem_data;
            r_instr_pc <= r_pc;
        end else begin
            r_instr    <= r_instr;
            r_instr_pc <= r_instr_pc;
        end
    end

    // Stack control derived from the accepted instruction
    always_comb begin
        w_push     = w_accept & bus.is_call;
        w_pop      = w_accept & bus.is_ret;
        w_push_val = r_instr_pc + PC_W'(1);
        w_top_idx  = r_ptr - PTR_W'(1);
        w_empty    = (r_cnt == {CNT_W{1'b0}});
        w_full     = (r_cnt == CNT_W'(RAS_DEPTH));
    end

    // Circular return-address stack; r_ptr is the next free slot, overflow overwrites the oldest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= {PC_W{1'b0}};
            end
            r_ptr     <= {PTR_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_ras_err <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_ras[r_ptr] <= w_push_val;
                    r_ptr        <= r_ptr + PTR_W'(1);
                    if (w_full) begin
                        r_ras_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        r_ras_err <= 1'b1;
                    end else begin
                        r_ptr <= w_top_idx;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                2'b11: begin
                    if (w_empty) begin
                        r_ras[r_ptr] <= w_push_val;
                        r_ptr        <= r_ptr + PTR_W'(1);
                        r_cnt        <= CNT_W'(1);
                    end else begin
                        r_ras[w_top_idx] <= w_push_val;
                    end
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.imem_en     = r_imem_en;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = r_halted;
    assign bus.ras_err     = r_ras_err;
    assign bus.ra          = w_empty ? 32'h0000_0000 : {{(32 - PC_W){1'b0}}, r_ras[w_top_idx]};
endmodule
